lsu_multi: RTL and testbench

- Next-generation load/store unit between the core MEM stage and the data-memory request/grant/rvalid bus.
- Adds parametrised data width, byte/half/word/dword accesses with byte enables, load sign/zero extension and misalignment detection.
- Posts stores with up to MAX_OUTST transactions in flight.
- Loads stay blocking: the pipeline stalls until the load's own response returns. Responses arrive in order.

---
 rtl/lsu_multi_if.sv | 22 ++
 rtl/lsu_multi.sv | 107 ++++++++++
 tb/tb_lsu_multi.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_multi_if.sv
// lsu_multi_if: request/grant/rvalid data-memory bus between the LSU and memory
interface lsu_multi_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                mem_req;
  logic                mem_gnt;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_we;
  logic [DATA_W/8-1:0] mem_be;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_rvalid;
  logic [DATA_W-1:0]   mem_rdata;
  modport master (
    output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );
  modport slave (
    input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_multi.sv
// lsu_multi: load/store unit with posted stores, blocking loads and sub-word lane handling
module lsu_multi #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              HZ_data_req,
  input  logic              mem_en,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy_out,
  output logic [DATA_W-1:0] data_out,
  output logic              misalign_out,
  lsu_multi_if.master       bus
);
  localparam int BW = DATA_W / 8;
  localparam int OW = $clog2(BW);
  localparam int PW = MAX_OUTST > 1 ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST + 1);
  typedef struct packed {
    logic          ld;
    logic [1:0]    sz;
    logic          uns;
    logic [OW-1:0] off;
  } meta_t;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_LD} state_t;
  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  meta_t             r_fifo [MAX_OUTST];
  logic [PW-1:0]     r_wp, r_rp;
  logic [DATA_W-1:0] r_data;
  logic [OW-1:0]     w_off;
  logic              w_mis, w_issue, w_legal, w_full, w_req, w_hs, w_rv, w_ld_rv;
  meta_t             w_head;
  logic [DATA_W-1:0] w_sh, w_up, w_ext;
  logic [6:0]        w_nb, w_sa;
  logic [BW-1:0]     w_be;
  assign w_off   = addr_in[OW-1:0];
  assign w_mis   = (size == 2'd1 & addr_in[0]) | (size == 2'd2 & |addr_in[1:0]) |
                   (size == 2'd3 & (|addr_in[2:0] | DATA_W == 32));
  assign w_issue = mem_en & HZ_data_req & (r_state == IDLE);
  assign w_legal = w_issue & ~w_mis;
  assign w_full  = r_cnt == CW'(MAX_OUTST);
  assign w_req   = (w_legal | r_state == REQ) & ~w_full;
  assign w_hs    = w_req & bus.mem_gnt;
  assign w_rv    = bus.mem_rvalid & (r_cnt != '0);
  assign w_head  = r_fifo[r_rp];
  assign w_ld_rv = w_rv & w_head.ld;
  // Sign/zero extension: push the field to the MSB, then shift back arithmetically or logically.
  assign w_sh  = bus.mem_rdata >> {w_head.off, 3'b000};
  assign w_nb  = 7'd8 << w_head.sz;
  assign w_sa  = (w_nb >= 7'(DATA_W)) ? 7'd0 : 7'(DATA_W) - w_nb;
  assign w_up  = w_sh << w_sa;
  assign w_ext = w_head.uns ? w_up >> w_sa : $unsigned($signed(w_up) >>> w_sa);
  assign w_be  = (size == 2'd0 ? BW'(1) : size == 2'd1 ? BW'(3) : size == 2'd2 ? BW'(15) : {BW{1'b1}}) << w_off;
  assign bus.mem_req   = w_req;
  assign bus.mem_addr  = {addr_in[ADDR_W-1:OW], {OW{1'b0}}};
  assign bus.mem_we    = wr;
  assign bus.mem_be    = w_be;
  assign bus.mem_wdata = size == 2'd0 ? {BW{data_in[7:0]}} :
                         size == 2'd1 ? {(DATA_W/16){data_in[15:0]}} :
                         size == 2'd2 ? {(DATA_W/32){data_in[31:0]}} : data_in;
  assign data_out      = r_data;
  assign misalign_out  = w_issue & w_mis;
  always_comb begin
    w_next   = r_state;
    busy_out = 1'b0;
    case (r_state)
      IDLE: if (w_legal) begin
        busy_out = ~(w_hs & wr);
        w_next   = w_hs ? (wr ? IDLE : WAIT_LD) : REQ;
      end
      REQ: begin
        busy_out = ~(w_hs & wr);
        w_next   = w_hs ? (wr ? IDLE : WAIT_LD) : REQ;
      end
      WAIT_LD: begin
        busy_out = ~w_ld_rv;
        w_next   = w_ld_rv ? IDLE : WAIT_LD;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= r_cnt + CW'(w_hs) - CW'(w_rv);
      if (w_hs) begin
        r_fifo[r_wp] <= {~wr, size, unsigned_ld, w_off};
        r_wp         <= (r_wp == PW'(MAX_OUTST - 1)) ? '0 : r_wp + 1'b1;
      end
      if (w_rv) r_rp <= (r_rp == PW'(MAX_OUTST - 1)) ? '0 : r_rp + 1'b1;
      if (w_ld_rv) r_data <= w_ext;
    end
  end
endmodule

// File: tb/tb_lsu_multi.sv
// tb_lsu_multi: table vectors, corner sequences and randomized transactions against a spec-level model
module tb_lsu_multi;
  logic        CLK = 0, RSTn = 0, hz = 0, mem_en = 0, wr = 0, uns = 0;
  logic [1:0]  size = 0;
  logic [31:0] addr_in = 0, data_in = 0, data_out;
  logic        busy_out, misalign_out;
  int          n_chk = 0, n_fail = 0;
  logic [31:0] exp_dout;
  lsu_multi_if #(.ADDR_W(32), .DATA_W(32)) bus();
  lsu_multi #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(2)) dut (
    .CLK(CLK), .RSTn(RSTn), .HZ_data_req(hz), .mem_en(mem_en), .wr(wr), .size(size),
    .unsigned_ld(uns), .addr_in(addr_in), .data_in(data_in), .busy_out(busy_out),
    .data_out(data_out), .misalign_out(misalign_out), .bus(bus)
  );
  always #5 CLK = ~CLK;
  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  function automatic logic f_mis(input logic [1:0] sz, input logic [31:0] a);
    return sz == 2'd3 || (a % (32'd1 << sz)) != 0;
  endfunction
  function automatic logic [3:0] f_be(input logic [1:0] sz, input logic [31:0] a);
    int nb = 1 << sz;
    logic [3:0] r = 0;
    for (int i = 0; i < 4; i++) if (i >= a % 4 && i < a % 4 + nb) r[i] = 1'b1;
    return r;
  endfunction
  function automatic logic [31:0] f_wd(input logic [1:0] sz, input logic [31:0] d);
    int nb = 1 << sz;
    logic [31:0] r = 0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
    return r;
  endfunction
  function automatic logic [31:0] f_ext(input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] rd);
    int nbits = 8 << sz;
    logic [63:0] mask = (64'd1 << nbits) - 1;
    logic [63:0] v = ({32'd0, rd} >> (8 * (a % 4))) & mask;
    if (!u && v[nbits-1]) v = v | ~mask;
    return v[31:0];
  endfunction
  task automatic txn(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a, d, rd,
                     input int gd, rdl, output logic o_mis, o_req, output logic [31:0] o_addr,
                     output logic [3:0] o_be, output logic [31:0] o_wd, output int o_busy,
                     output logic [31:0] o_dout, output logic ok);
    int gc = -1;
    logic done = 0;
    o_busy = 0; o_mis = 0; o_req = 0; o_addr = 0; o_be = 0; o_wd = 0;
    mem_en = 1; hz = 1; wr = w; size = sz; uns = u; addr_in = a; data_in = d;
    bus.mem_rdata = rd;
    for (int c = 0; c < 30 && !done; c++) begin
      bus.mem_gnt    = (gc < 0) && (c >= gd);
      bus.mem_rvalid = (gc >= 0) && !w && (c == gc + 1 + rdl);
      @(negedge CLK);
      if (c == 0) begin
        o_mis = misalign_out; o_req = bus.mem_req; o_addr = bus.mem_addr;
        o_be = bus.mem_be; o_wd = bus.mem_wdata;
      end
      o_busy += int'(busy_out);
      if (misalign_out) done = 1;
      else if (bus.mem_req && bus.mem_gnt) begin
        gc = c;
        if (w) done = 1;
      end else if (bus.mem_rvalid) done = 1;
      tick();
    end
    ok = done;
    mem_en = 0; bus.mem_gnt = 0; bus.mem_rvalid = 0;
    if (done && w && !o_mis) begin
      bus.mem_rvalid = 1;
      tick();
      bus.mem_rvalid = 0;
    end
    @(negedge CLK);
    o_dout = data_out;
    tick();
  endtask
  typedef struct {
    logic w; logic [1:0] sz; logic u; logic [31:0] a, d, rd;
    logic mis; logic [31:0] ea; logic [3:0] be; logic [31:0] wd; int busy; logic [31:0] dout;
  } vec_t;
  vec_t tbl[8];
  logic        o_mis, o_req, ok;
  logic [31:0] o_addr, o_wd, o_dout;
  logic [3:0]  o_be;
  int          o_busy;
  initial begin
    tbl[0] = '{0, 2, 0, 32'h100, 0, 32'hDEADBEEF, 0, 32'h100, 4'hF, 0, 3, 32'hDEADBEEF};
    tbl[1] = '{0, 0, 0, 32'h103, 0, 32'h80FFFFFF, 0, 32'h100, 4'h8, 0, 3, 32'hFFFFFF80};
    tbl[2] = '{0, 0, 1, 32'h103, 0, 32'h80FFFFFF, 0, 32'h100, 4'h8, 0, 3, 32'h00000080};
    tbl[3] = '{1, 1, 0, 32'h102, 32'hABCD, 0, 0, 32'h100, 4'hC, 32'hABCDABCD, 0, 32'h00000080};
    tbl[4] = '{0, 2, 0, 32'h101, 0, 32'h11111111, 1, 0, 0, 0, 0, 32'h00000080};
    tbl[5] = '{0, 3, 0, 32'h100, 0, 32'h22222222, 1, 0, 0, 0, 0, 32'h00000080};
    tbl[6] = '{0, 1, 0, 32'h102, 0, 32'h80011234, 0, 32'h100, 4'hC, 0, 3, 32'hFFFF8001};
    tbl[7] = '{1, 0, 0, 32'h201, 32'h5A, 0, 0, 32'h200, 4'h2, 32'h5A5A5A5A, 0, 32'hFFFF8001};
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    #1;
    tick(); tick();
    RSTn = 1;
    @(negedge CLK);
    chk("rst_busy", 32'(busy_out), 0);
    chk("rst_req", 32'(bus.mem_req), 0);
    chk("rst_mis", 32'(misalign_out), 0);
    chk("rst_dout", data_out, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      txn(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].d, tbl[i].rd, 0, 2,
          o_mis, o_req, o_addr, o_be, o_wd, o_busy, o_dout, ok);
      chk($sformatf("t%0d_done", i), 32'(ok), 1);
      chk($sformatf("t%0d_mis", i), 32'(o_mis), 32'(tbl[i].mis));
      chk($sformatf("t%0d_req", i), 32'(o_req), 32'(!tbl[i].mis));
      chk($sformatf("t%0d_busy", i), o_busy, tbl[i].busy);
      chk($sformatf("t%0d_dout", i), o_dout, tbl[i].dout);
      if (!tbl[i].mis) begin
        chk($sformatf("t%0d_addr", i), o_addr, tbl[i].ea);
        chk($sformatf("t%0d_be", i), 32'(o_be), 32'(tbl[i].be));
        if (tbl[i].w) chk($sformatf("t%0d_wd", i), o_wd, tbl[i].wd);
      end
    end
    exp_dout = tbl[7].dout;
    // Misaligned issue must not count; then two posted stores fill the window.
    mem_en = 1; hz = 1; wr = 0; size = 2; addr_in = 32'h101; bus.mem_gnt = 1;
    @(negedge CLK);
    chk("sq_mis", 32'(misalign_out), 1);
    chk("sq_mis_req", 32'(bus.mem_req), 0);
    tick();
    wr = 1; addr_in = 32'h300; data_in = 32'h11111111;
    @(negedge CLK);
    chk("sq_s1_req", 32'(bus.mem_req), 1);
    chk("sq_s1_busy", 32'(busy_out), 0);
    tick();
    addr_in = 32'h304;
    @(negedge CLK);
    chk("sq_s2_req", 32'(bus.mem_req), 1);
    chk("sq_s2_busy", 32'(busy_out), 0);
    tick();
    addr_in = 32'h308;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      chk("sq_full_req", 32'(bus.mem_req), 0);
      chk("sq_full_busy", 32'(busy_out), 1);
      tick();
    end
    bus.mem_rvalid = 1;
    @(negedge CLK);
    chk("sq_rv_req", 32'(bus.mem_req), 0);
    chk("sq_rv_busy", 32'(busy_out), 1);
    tick();
    bus.mem_rvalid = 0;
    @(negedge CLK);
    chk("sq_s3_req", 32'(bus.mem_req), 1);
    chk("sq_s3_busy", 32'(busy_out), 0);
    chk("sq_s3_addr", bus.mem_addr, 32'h308);
    tick();
    mem_en = 0; bus.mem_gnt = 0; bus.mem_rvalid = 1;
    tick(); tick();
    bus.mem_rvalid = 0;
    @(negedge CLK);
    chk("sq_dout_hold", data_out, exp_dout);
    tick();
    for (int i = 0; i < 60; i++) begin
      logic w, u, m;
      logic [1:0] sz;
      logic [31:0] a, d, rd;
      int gd, rdl;
      w = 1'($urandom_range(0, 1)); u = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3));
      a = $urandom & 32'hFFFC_0FFF; d = $urandom; rd = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
      gd = $urandom_range(0, 2); rdl = $urandom_range(0, 2);
      m = f_mis(sz, a);
      txn(w, sz, u, a, d, rd, gd, rdl, o_mis, o_req, o_addr, o_be, o_wd, o_busy, o_dout, ok);
      chk("r_done", 32'(ok), 1);
      chk("r_mis", 32'(o_mis), 32'(m));
      chk("r_req", 32'(o_req), 32'(!m));
      if (!m) begin
        chk("r_addr", o_addr, a & ~32'd3);
        chk("r_be", 32'(o_be), 32'(f_be(sz, a)));
        if (w) chk("r_wd", o_wd, f_wd(sz, d));
        chk("r_busy", o_busy, w ? gd : gd + 1 + rdl);
        if (!w) exp_dout = f_ext(sz, u, a, rd);
      end else chk("r_busy_mis", o_busy, 0);
      chk("r_dout", o_dout, exp_dout);
    end
    // Load with a late grant, then reset while waiting for its data.
    mem_en = 1; hz = 1; wr = 0; size = 2; addr_in = 32'h400; bus.mem_gnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("rs_req", 32'(bus.mem_req), 1);
      chk("rs_busy", 32'(busy_out), 1);
      tick();
    end
    bus.mem_gnt = 1;
    tick();
    bus.mem_gnt = 0; mem_en = 0;
    @(negedge CLK);
    chk("rs_wait_busy", 32'(busy_out), 1);
    chk("rs_wait_req", 32'(bus.mem_req), 0);
    RSTn = 0;
    tick();
    RSTn = 1; bus.mem_rvalid = 1; bus.mem_rdata = 32'h12345678;
    @(negedge CLK);
    chk("rs_busy_after", 32'(busy_out), 0);
    chk("rs_dout_rst", data_out, 0);
    tick();
    bus.mem_rvalid = 0;
    @(negedge CLK);
    chk("rs_stale_dout", data_out, 0);
    tick();
    txn(0, 2, 0, 32'h500, 0, 32'hFEEDFACE, 0, 0, o_mis, o_req, o_addr, o_be, o_wd, o_busy, o_dout, ok);
    chk("rs_post_done", 32'(ok), 1);
    chk("rs_post_busy", o_busy, 1);
    chk("rs_post_dout", o_dout, 32'hFEEDFACE);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
